rr_burst_scheduler: RTL
=======================

Name: rr_burst_scheduler

Overview:
- Round-robin scheduler that shares one registered output stage (a DATA_W capture register with valid/ready) between NUM_REQ requesters.
- Grants one requester at a time and holds the grant for bursts of up to MAX_BURST beats.
- Tags every output beat with the source ID.
- Sits in front of shared sequential datapath stages in the process-domain test designs.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, 16: payload width.
- MAX_BURST, 4: maximum consecutive beats per grant, 1..15.
- ID_W, 2: source ID width, must equal clog2(NUM_REQ).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- req_valid  input  NUM_REQ  per-requester beat valid.
- req_data  input  NUM_REQ*DATA_W  packed payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_data  output  DATA_W  registered payload.
- out_id  output  ID_W  index of the requester that supplied out_data.
- out_ready  input  1  downstream accept.
- busy  output  1  high when state is HOLD or out_valid is high.

Behaviour:
- Reset is asynchronous on rst low. State goes to ARB, rr_ptr=0, owner=0, burst_cnt=0, out_valid=0, out_data=0, out_id=0. req_ready is forced to all-zero while rst is low.
- pipe_ready = !out_valid || out_ready.
- A transfer of requester i happens when req_valid[i] && req_ready[i].
  - On a transfer: out_data <= req_data[i], out_id <= i, out_valid <= 1.
  - Latency is 1 cycle from accept to out_valid.
- out_valid clears on out_ready when no new transfer occurs in the same cycle. A simultaneous pop and push is a full-throughput replace.
- Output beats are never dropped or duplicated.
- While out_valid && !out_ready:
  - out_data and out_id stay stable.
  - req_ready is all-zero.
  - State, burst_cnt and rr_ptr do not change.
- ARB state:
  - sel = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[sel] = pipe_ready. All other requesters get 0. No valid requester means no grant.
  - On a transfer with MAX_BURST==1: stay in ARB, rr_ptr <= sel+1 mod NUM_REQ.
  - On a transfer with MAX_BURST>1: go to HOLD, owner <= sel, burst_cnt <= 1.
- HOLD state:
  - Only the owner is eligible: req_ready[owner] = pipe_ready && req_valid[owner]. Other requesters get 0 even if valid.
  - Owner transfer with burst_cnt+1 == MAX_BURST: go to ARB, burst_cnt <= 0, rr_ptr <= owner+1 mod NUM_REQ.
  - Owner transfer otherwise: burst_cnt increments.
  - Owner req_valid low while pipe_ready: no transfer that cycle. Go to ARB, burst_cnt <= 0, rr_ptr <= owner+1. This costs exactly one bubble cycle.
  - Owner req_valid low while stalled: hold, with no release and no state change.
- Wrap-around: rr_ptr and the search wrap from NUM_REQ-1 to 0. burst_cnt never exceeds MAX_BURST-1 in HOLD.
- Fairness: a requester that stays valid is granted within (NUM_REQ-1)*(MAX_BURST+1)+1 pipe_ready cycles.
- A requester dropping req_valid without a transfer is legal; this block does not enforce data stability.
- Reset mid-burst: the in-flight output beat is discarded, and arbitration restarts from requester 0 after rst deasserts.
- ID_W/NUM_REQ mismatch is an elaboration error via an assertion.

Test Plan:
- MAX_BURST=1, all four req_valid held high, out_ready=1 → out_id sequence 0,1,2,3,0,… one beat per cycle. req_ready is one-hot rotating.
- MAX_BURST=4, req1 streams 6 beats, req2 valid throughout → out_id 1,1,1,1,2,…,1,1. The grant returns to req1 only after req2 and any other valid requester.
- Backpressure: out_ready=0 for 3 cycles with out_data=16'hA5A5 → out_data/out_id stable, req_ready=0, burst_cnt frozen. Release gives the next beat with no loss.
- HOLD owner 2 drops req_valid after 2 beats, req3 valid → exactly one cycle of no transfer, then out_id=3. rr_ptr moves past 2.
- Single requester 3 only, MAX_BURST=4, continuous → 4 beats, one ARB re-grant with no bubble (ARB grants in the same cycle), then continuous. Expected sequence 3,3,3,3,3,…
- rst pulsed low mid-burst (owner 1, burst_cnt=2, out_valid=1) → out_valid drops asynchronously to 0. After release with all requesters valid, the first out_id is 0.

Source files
------------

// File: rtl/rr_burst_scheduler.sv
// rtl/rr_burst_scheduler.sv - round-robin burst scheduler feeding one registered output stage
module rr_burst_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4,
    parameter int ID_W      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [ID_W-1:0]           out_id,
    input  logic                      out_ready,
    output logic                      busy
);

    // The source ID must exactly cover the requester range.
    if (ID_W != $clog2(NUM_REQ)) begin : g_id_w_check
        $fatal(1, "rr_burst_scheduler: ID_W must equal clog2(NUM_REQ)");
    end

    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_burst_check
        $fatal(1, "rr_burst_scheduler: MAX_BURST must be 1..15");
    end

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // One extra bit so rr_ptr + offset can exceed NUM_REQ-1 before wrapping.
    localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [3:0]    BURST_END = 4'(MAX_BURST);

    state_t          state, state_nxt;
    logic [ID_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [ID_W-1:0] owner, owner_nxt;
    logic [3:0]      burst_cnt, burst_cnt_nxt;
    logic [ID_W-1:0] sel;
    logic [ID_W-1:0] xfer_id;
    logic [ID_W:0]   cand;
    logic            found;
    logic            pipe_ready;
    logic            xfer;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx);
        if ({1'b0, idx} == NUM_REQ_W - (ID_W+1)'(1)) begin
            return '0;
        end
        return idx + ID_W'(1);
    endfunction

    assign pipe_ready = !out_valid || out_ready;
    assign xfer_id    = (state == ARB) ? sel : owner;
    assign xfer       = |(req_valid & req_ready);
    assign busy       = (state == HOLD) || out_valid;

    // Rotating priority search: first valid requester at or after rr_ptr.
    always_comb begin
        found = 1'b0;
        sel   = rr_ptr;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!found && req_valid[cand[ID_W-1:0]]) begin
                found = 1'b1;
                sel   = cand[ID_W-1:0];
            end
        end
    end

    // Grant: arbitration winner in ARB, only the owner in HOLD; nothing during reset or stall.
    always_comb begin
        req_ready = '0;
        if (rst && pipe_ready) begin
            if (state == ARB) begin
                if (found) begin
                    req_ready[sel] = 1'b1;
                end
            end else begin
                req_ready[owner] = req_valid[owner];
            end
        end
    end

    // Burst bookkeeping: enter HOLD on a grant, leave on burst end or owner going idle.
    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        owner_nxt     = owner;
        burst_cnt_nxt = burst_cnt;
        case (state)
            ARB: begin
                if (xfer) begin
                    if (MAX_BURST == 1) begin
                        rr_ptr_nxt = wrap_inc(sel);
                    end else begin
                        state_nxt     = HOLD;
                        owner_nxt     = sel;
                        burst_cnt_nxt = 4'd1;
                    end
                end
            end
            HOLD: begin
                if (xfer) begin
                    if (burst_cnt + 4'd1 == BURST_END) begin
                        state_nxt     = ARB;
                        burst_cnt_nxt = '0;
                        rr_ptr_nxt    = wrap_inc(owner);
                    end else begin
                        burst_cnt_nxt = burst_cnt + 4'd1;
                    end
                end else if (pipe_ready) begin
                    // Owner went idle while the pipe could accept: give up the grant.
                    state_nxt     = ARB;
                    burst_cnt_nxt = '0;
                    rr_ptr_nxt    = wrap_inc(owner);
                end
            end
            default: begin
                state_nxt = ARB;
            end
        endcase
    end

    // Scheduler state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ARB;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            owner     <= owner_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // Output capture register: load on transfer, empty on pop without a replacing push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= req_data[xfer_id*DATA_W +: DATA_W];
            out_id    <= xfer_id;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
